bayer_to_gray: RTL
==================

# bayer_to_gray

Converts the raw Bayer-mosaic pixel stream from the camera capture path into a half-resolution grayscale stream for the Sobel convolution stage that follows. Each 2x2 Bayer quad (R, G, G, B) is averaged into one DATA_WIDTH-bit gray pixel. The output valid/value pair drives the convolution input directly. An internal one-row buffer holds the even-row pair sums until the matching odd-row pixels arrive.

## Interface
- DATA_WIDTH, 12: bit width of raw input pixels and of the gray output.
- IMG_WIDTH, 640: input pixels per row. Must be even and ≥ 4.
- i_clk  input  1  clock; all logic rises on the positive edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_val_valid  input  1  qualifies i_val and i_sof; pixels are accepted only when high.
- i_val  input  DATA_WIDTH  raw Bayer pixel in raster order.
- i_sof  input  1  start of frame; marks the current valid pixel as row 0, column 0.
- o_val_valid  output  1  gray pixel valid, one-cycle pulse per output pixel.
- o_val  output  DATA_WIDTH  gray pixel value.
- o_sof  output  1  high together with o_val_valid on the first gray pixel of a frame.

## Operation
- Counters:
  - col runs 0..IMG_WIDTH-1 and advances only on accepted pixels; it wraps to 0 after IMG_WIDTH-1.
  - Each column wrap toggles the row state.
- States:
  - IDLE: the reset state. All pixels are ignored.
  - EVEN_ROW, ODD_ROW: active-row states.
- Transitions:
  - Any state with i_val_valid and i_sof goes to EVEN_ROW with col=0. The pixel carrying i_sof is consumed as column 0.
  - EVEN_ROW → ODD_ROW on wrap.
  - ODD_ROW → EVEN_ROW on wrap.
- EVEN_ROW:
  - An even column latches the pixel in a hold register.
  - An odd column writes hold + pixel (DATA_WIDTH+1 bits) to buffer address col>>1.
- ODD_ROW:
  - An even column latches the pixel and issues a buffer read at col>>1.
  - An odd column forms sum = buffer_data + hold + pixel (DATA_WIDTH+2 bits) and registers o_val = sum[DATA_WIDTH+1:2]. This is a floor divide by 4 with no rounding and no saturation; overflow is impossible.
- The buffer read data stays valid until the next read, so gaps between pixels (i_val_valid low) never corrupt a result.
- o_sof is set by the first output after i_sof and cleared after that output.
- Frames with an odd row count: the trailing even row produces no output. Each frame yields (IMG_WIDTH/2)·floor(rows/2) outputs.
- i_sof arriving mid-row or mid-frame restarts counters immediately. Partial pairs already held are discarded, and no output comes from them.

## Timing
- Reset values: o_val_valid=0, o_val=0, o_sof=0, state=IDLE, col=0, hold=0. Buffer contents are don't-care.
- Latency: o_val_valid rises exactly 1 cycle after the accepting edge of the odd-row odd-column pixel. o_val_valid is high for exactly one cycle.
- Maximum output rate is one pixel per 2 input cycles, so the output pulses are never back-to-back.
- Buffer: synchronous write and registered read with 1-cycle read latency. The read issued at the even column completes before the next accepted pixel, even at full rate.
- Reset asserted mid-operation clears all outputs asynchronously within the same cycle. Afterwards the block stays in IDLE until the next i_sof.
- Simultaneous buffer write and read cannot happen, because write and read occur in different row states.

## Structure
- bayer_pkg holds:
  - state_t enum {IDLE, EVEN_ROW, ODD_ROW}
  - localparams PAIR_W = DATA_WIDTH+1 and QUAD_W = DATA_WIDTH+2
  - a function col_w(IMG_WIDTH) = $clog2(IMG_WIDTH)
- Sub-module pair_line_buffer: simple dual-port RAM, depth IMG_WIDTH/2, width PAIR_W, with wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data registered on rd_en. It must be inferable as block RAM.
- Top level holds the FSM, the counters, the hold register, the adder and the output register.

## Test plan
All scenarios use IMG_WIDTH=4 and DATA_WIDTH=12.
- Reset, then drive 8 valid pixels without i_sof → no o_val_valid; o_val=0 and o_sof=0 throughout.
- Frame with i_sof: row0 = 100,200,300,400 and row1 = 500,600,700,800 → outputs 350 (with o_sof=1), then 550 (o_sof=0). Each output arrives 1 cycle after pixels 600 and 800.
- Arithmetic boundaries:
  - All-4095 quad → 4095.
  - Quad 1,1,1,0 → 0 (floor).
  - Quad 3,3,3,3 → 3.
- Repeat the scenario-2 frame with random i_val_valid gaps of 0–5 cycles → identical outputs 350 and 550. No two output pulses are adjacent.
- Send row0 of a frame, then i_sof on row1 column 1, then a full new frame of all-1000 pixels → exactly 2 outputs of 1000. Nothing comes from the aborted data.
- Assert i_rst_n low during row1 column 2 → o_val_valid drops immediately. Continuing pixels without i_sof produce no output; a new frame produces the correct results.

Source files
------------

// File: rtl/bayer_to_gray_pkg.sv
// Shared types and widths for the Bayer-to-gray converter.
//   state_t : row-tracking FSM states
//   PAIR_W  : width of a two-pixel sum at the default pixel width
//   QUAD_W  : width of a four-pixel sum at the default pixel width
//   col_w() : column counter width for a given row length
package bayer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } state_t;

    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam int unsigned PAIR_W         = DATA_WIDTH_DEF + 1;
    localparam int unsigned QUAD_W         = DATA_WIDTH_DEF + 2;

    function automatic int unsigned col_w(input int unsigned img_width);
        return $clog2(img_width);
    endfunction

endpackage

// File: rtl/bayer_to_gray_if.sv
// Pixel stream bundle between the capture path, the converter and the Sobel stage.
//   i_val_valid/i_val/i_sof : raw Bayer pixels into the converter
//   o_val_valid/o_val/o_sof : gray pixels out of the converter
//   slave  : converter view;  master : driver/consumer view
interface bayer_to_gray_if #(
    parameter int unsigned DATA_WIDTH = 12
) ();
    logic                  i_val_valid;
    logic [DATA_WIDTH-1:0] i_val;
    logic                  i_sof;
    logic                  o_val_valid;
    logic [DATA_WIDTH-1:0] o_val;
    logic                  o_sof;

    modport slave (
        input  i_val_valid, i_val, i_sof,
        output o_val_valid, o_val, o_sof
    );

    modport master (
        output i_val_valid, i_val, i_sof,
        input  o_val_valid, o_val, o_sof
    );
endinterface

// File: rtl/bayer_to_gray_pair_line_buffer.sv
// One-row store of even-row pair sums; simple dual-port RAM.
//   i_clk                          : clock
//   i_wr_en/i_wr_addr/i_wr_data    : synchronous write port
//   i_rd_en/i_rd_addr -> o_rd_data : registered read, 1-cycle latency, held until next read
module pair_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned WIDTH = 13,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // No reset so the array maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bayer_to_gray.sv
// Averages each 2x2 Bayer quad into one gray pixel (half resolution).
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : raw pixels in (i_val_valid/i_val/i_sof),
//                    gray pixels out (o_val_valid/o_val/o_sof)
module bayer_to_gray
    import bayer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned IMG_WIDTH  = 640
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bayer_to_gray_if.slave  bus
);

    localparam int unsigned CW = col_w(IMG_WIDTH);
    localparam int unsigned AW = CW - 1;
    // Package widths track the default pixel width; rescale for overrides
    localparam int unsigned PW = PAIR_W + DATA_WIDTH - DATA_WIDTH_DEF;
    localparam int unsigned QW = QUAD_W + DATA_WIDTH - DATA_WIDTH_DEF;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    state_t                r_state;
    logic [CW-1:0]         r_col;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_sof_pend;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_val;
    logic                  r_out_sof;

    logic                  w_restart;
    logic                  w_step;
    logic                  w_odd_col;
    logic                  w_wrap;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [AW-1:0]         w_addr;
    logic [PW-1:0]         w_pair;
    logic [PW-1:0]         w_rd_data;
    logic [QW-1:0]         w_sum;

    assign w_restart = bus.i_val_valid & bus.i_sof;
    assign w_step    = bus.i_val_valid & ~bus.i_sof;
    assign w_odd_col = r_col[0];
    assign w_wrap    = (r_col == COL_LAST);
    assign w_wr_en   = w_step && (r_state == EVEN_ROW) && w_odd_col;
    assign w_rd_en   = w_step && (r_state == ODD_ROW) && !w_odd_col;
    assign w_addr    = r_col[CW-1:1];
    assign w_pair    = PW'(r_hold) + PW'(bus.i_val);
    assign w_sum     = QW'(w_rd_data) + QW'(r_hold) + QW'(bus.i_val);

    pair_line_buffer #(
        .DEPTH (IMG_WIDTH / 2),
        .WIDTH (PW),
        .AW    (AW)
    ) u_line_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_addr),
        .i_wr_data (w_pair),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_addr),
        .o_rd_data (w_rd_data)
    );

    // Row FSM, column counter, hold register and output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_hold      <= '0;
            r_sof_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_val   <= '0;
            r_out_sof   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            if (w_restart) begin
                // SOF pixel is column 0 of an even row; any partial data is dropped
                r_state    <= EVEN_ROW;
                r_col      <= CW'(1);
                r_hold     <= bus.i_val;
                r_sof_pend <= 1'b1;
            end else if (w_step && (r_state != IDLE)) begin
                r_col <= w_wrap ? '0 : r_col + CW'(1);
                if (!w_odd_col) begin
                    r_hold <= bus.i_val;
                end
                if (w_wrap) begin
                    r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end
                if ((r_state == ODD_ROW) && w_odd_col) begin
                    r_out_valid <= 1'b1;
                    r_out_val   <= DATA_WIDTH'(w_sum >> 2);
                    r_out_sof   <= r_sof_pend;
                    r_sof_pend  <= 1'b0;
                end
            end
        end
    end

    assign bus.o_val_valid = r_out_valid;
    assign bus.o_val       = r_out_val;
    assign bus.o_sof       = r_out_sof;

endmodule
